// File: rtl/line_setup_controller.sv
// Line-draw setup sequencer: accepts two endpoints and normalises the line into
// an x-major, left-to-right Bresenham configuration before driving the fragment generator.
module line_setup_controller #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] x0_in,
  input  logic [WIDTH-1:0] y0_in,
  input  logic [WIDTH-1:0] x1_in,
  input  logic [WIDTH-1:0] y1_in,
  input  logic             finish,
  output logic             start,
  output logic             en_FB_reg,
  output logic             steep,
  output logic [WIDTH-1:0] deltax,
  output logic [WIDTH-1:0] deltay,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] ystep,
  output logic [WIDTH-1:0] x0,
  output logic [WIDTH-1:0] x_min,
  output logic [WIDTH-1:0] x_max,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    SETUP_STEEP = 3'd1,
    SETUP_ORDER = 3'd2,
    SETUP_DELTA = 3'd3,
    START       = 3'd4,
    DRAW        = 3'd5,
    DONE        = 3'd6
  } state_t;

  localparam logic [WIDTH-1:0] STEP_POS = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] STEP_NEG = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};

  state_t           state_r;
  logic [WIDTH-1:0] wx0_r, wy0_r, wx1_r, wy1_r;
  logic [WIDTH:0]   adx_s, ady_s;
  logic             steep_s;

  // Absolute endpoint separations, one bit wider so the subtraction cannot wrap.
  always_comb begin
    adx_s   = {(WIDTH+1){1'b0}};
    ady_s   = {(WIDTH+1){1'b0}};
    if (wx1_r >= wx0_r) begin
      adx_s = {1'b0, wx1_r} - {1'b0, wx0_r};
    end else begin
      adx_s = {1'b0, wx0_r} - {1'b0, wx1_r};
    end
    if (wy1_r >= wy0_r) begin
      ady_s = {1'b0, wy1_r} - {1'b0, wy0_r};
    end else begin
      ady_s = {1'b0, wy0_r} - {1'b0, wy1_r};
    end
    steep_s = (ady_s > adx_s);
  end

  // Sequencer: state, working endpoints and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      start     <= 1'b0;
      en_FB_reg <= 1'b0;
      done      <= 1'b0;
      steep     <= 1'b0;
      deltax    <= ZERO_W;
      deltay    <= ZERO_W;
      y0        <= ZERO_W;
      ystep     <= ZERO_W;
      x0        <= ZERO_W;
      x_min     <= ZERO_W;
      x_max     <= ZERO_W;
      wx0_r     <= ZERO_W;
      wy0_r     <= ZERO_W;
      wx1_r     <= ZERO_W;
      wy1_r     <= ZERO_W;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid && req_ready) begin
            wx0_r     <= x0_in;
            wy0_r     <= y0_in;
            wx1_r     <= x1_in;
            wy1_r     <= y1_in;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state_r   <= SETUP_STEEP;
          end else begin
            state_r   <= IDLE;
          end
        end
        SETUP_STEEP: begin
          steep <= steep_s;
          if (steep_s) begin
            wx0_r <= wy0_r;
            wy0_r <= wx0_r;
            wx1_r <= wy1_r;
            wy1_r <= wx1_r;
          end else begin
            wx0_r <= wx0_r;
          end
          state_r <= SETUP_ORDER;
        end
        SETUP_ORDER: begin
          if (wx0_r > wx1_r) begin
            wx0_r <= wx1_r;
            wy0_r <= wy1_r;
            wx1_r <= wx0_r;
            wy1_r <= wy0_r;
          end else begin
            wx0_r <= wx0_r;
          end
          state_r <= SETUP_DELTA;
        end
        SETUP_DELTA: begin
          deltax <= wx1_r - wx0_r;
          if (wy0_r <= wy1_r) begin
            deltay <= wy1_r - wy0_r;
            ystep  <= STEP_POS;
          end else begin
            deltay <= wy0_r - wy1_r;
            ystep  <= STEP_NEG;
          end
          x0      <= wx0_r;
          x_min   <= wx0_r;
          x_max   <= wx1_r;
          y0      <= wy0_r;
          start   <= 1'b1;
          state_r <= START;
        end
        START: begin
          start     <= 1'b0;
          en_FB_reg <= 1'b1;
          state_r   <= DRAW;
        end
        DRAW: begin
          if (finish) begin
            en_FB_reg <= 1'b0;
            done      <= 1'b1;
            state_r   <= DONE;
          end else begin
            state_r   <= DRAW;
          end
        end
        DONE: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          req_ready <= 1'b1;
          state_r   <= IDLE;
        end
        default: begin
          start     <= 1'b0;
          en_FB_reg <= 1'b0;
          done      <= 1'b0;
          busy      <= 1'b0;
          req_ready <= 1'b1;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_setup_controller.sv
// Self-checking bench for line_setup_controller: directed vector table, handshake
// corner sequences, asynchronous reset mid-draw and randomized lines against a model.
module tb_line_setup_controller;

  localparam int W = 10;

  typedef struct {
    logic         steep;
    logic [W-1:0] deltax;
    logic [W-1:0] deltay;
    logic [W-1:0] y0;
    logic [W-1:0] ystep;
    logic [W-1:0] x0;
    logic [W-1:0] x_min;
    logic [W-1:0] x_max;
  } cfg_t;

  typedef struct {
    int   ax0;
    int   ay0;
    int   ax1;
    int   ay1;
    cfg_t exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] x0_in, y0_in, x1_in, y1_in;
  logic         finish;
  logic         start;
  logic         en_FB_reg;
  logic         steep;
  logic [W-1:0] deltax, deltay, y0, ystep, x0, x_min, x_max;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  line_setup_controller #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .x0_in(x0_in), .y0_in(y0_in), .x1_in(x1_in), .y1_in(y1_in),
    .finish(finish), .start(start), .en_FB_reg(en_FB_reg), .steep(steep),
    .deltax(deltax), .deltay(deltay), .y0(y0), .ystep(ystep), .x0(x0),
    .x_min(x_min), .x_max(x_max), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic cfg_t mk(input logic s, input int dx, input int dy, input int yy,
                              input int ys, input int xa, input int xb);
    cfg_t c;
    c.steep  = s;
    c.deltax = dx[W-1:0];
    c.deltay = dy[W-1:0];
    c.y0     = yy[W-1:0];
    c.ystep  = ys[W-1:0];
    c.x0     = xa[W-1:0];
    c.x_min  = xa[W-1:0];
    c.x_max  = xb[W-1:0];
    return c;
  endfunction

  // Reference: Bresenham normalisation expressed with plain integer arithmetic.
  function automatic cfg_t model(input int ax0, input int ay0, input int ax1, input int ay1);
    int p0x, p0y, p1x, p1y, t, adx, ady;
    logic s;
    adx = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
    ady = (ay1 > ay0) ? ay1 - ay0 : ay0 - ay1;
    s = (ady > adx);
    p0x = s ? ay0 : ax0;  p0y = s ? ax0 : ay0;
    p1x = s ? ay1 : ax1;  p1y = s ? ax1 : ay1;
    if (p0x > p1x) begin
      t = p0x; p0x = p1x; p1x = t;
      t = p0y; p0y = p1y; p1y = t;
    end
    return mk(s, p1x - p0x, (p1y >= p0y) ? p1y - p0y : p0y - p1y, p0y,
              (p0y <= p1y) ? 1 : (1 << W) - 1, p0x, p1x);
  endfunction

  task automatic chk_cfg(input string tag, input cfg_t e);
    chk({tag, ".steep"},  {31'd0, steep}, {31'd0, e.steep});
    chk({tag, ".deltax"}, {22'd0, deltax}, {22'd0, e.deltax});
    chk({tag, ".deltay"}, {22'd0, deltay}, {22'd0, e.deltay});
    chk({tag, ".y0"},     {22'd0, y0},     {22'd0, e.y0});
    chk({tag, ".ystep"},  {22'd0, ystep},  {22'd0, e.ystep});
    chk({tag, ".x0"},     {22'd0, x0},     {22'd0, e.x0});
    chk({tag, ".x_min"},  {22'd0, x_min},  {22'd0, e.x_min});
    chk({tag, ".x_max"},  {22'd0, x_max},  {22'd0, e.x_max});
  endtask

  task automatic chk_ctl(input string tag, input logic rdy, input logic bsy,
                         input logic st, input logic en, input logic dn);
    chk({tag, ".req_ready"}, {31'd0, req_ready}, {31'd0, rdy});
    chk({tag, ".busy"},      {31'd0, busy},      {31'd0, bsy});
    chk({tag, ".start"},     {31'd0, start},     {31'd0, st});
    chk({tag, ".en_FB_reg"}, {31'd0, en_FB_reg}, {31'd0, en});
    chk({tag, ".done"},      {31'd0, done},      {31'd0, dn});
  endtask

  // Accept one line, then follow it cycle by cycle through setup, START, DRAW and DONE.
  task automatic run_line(input string tag, input int ax0, input int ay0, input int ax1,
                          input int ay1, input cfg_t e, input int ndraw,
                          input bit fin_setup, input bit hold_v);
    @(negedge clk);
    chk({tag, ".idle_ready"}, {31'd0, req_ready}, 32'd1);
    x0_in = ax0[W-1:0];
    y0_in = ay0[W-1:0];
    x1_in = ax1[W-1:0];
    y1_in = ay1[W-1:0];
    req_valid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (!hold_v) req_valid = 1'b0;
      finish = fin_setup;
      chk_ctl($sformatf("%s.setup%0d", tag, c), 1'b0, 1'b1, (c == 4), 1'b0, 1'b0);
    end
    chk_cfg({tag, ".cfg"}, e);
    for (int d = 1; d <= ndraw; d++) begin
      @(negedge clk);
      finish = (d == ndraw);
      chk_ctl($sformatf("%s.draw%0d", tag, d), 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    end
    @(negedge clk);
    finish = 1'b0;
    req_valid = 1'b0;
    chk_ctl({tag, ".done"}, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk_ctl({tag, ".idle"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk_ctl({tag, ".idle2"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_cfg({tag, ".cfg_hold"}, e);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{ax0: 0,    ay0: 0, ax1: 10, ay1: 4,    exp: mk(1'b0, 10, 4, 0, 1, 0, 10)};
    vecs[1] = '{ax0: 2,    ay0: 1, ax1: 3,  ay1: 9,    exp: mk(1'b1, 8, 1, 2, 1, 1, 9)};
    vecs[2] = '{ax0: 8,    ay0: 2, ax1: 0,  ay1: 6,    exp: mk(1'b0, 8, 4, 6, 1023, 0, 8)};
    vecs[3] = '{ax0: 5,    ay0: 5, ax1: 5,  ay1: 5,    exp: mk(1'b0, 0, 0, 5, 1, 5, 5)};
    vecs[4] = '{ax0: 9,    ay0: 9, ax1: 1,  ay1: 1,    exp: mk(1'b0, 8, 8, 1, 1, 1, 9)};
    vecs[5] = '{ax0: 1023, ay0: 0, ax1: 0,  ay1: 1023, exp: mk(1'b0, 1023, 1023, 1023, 1023, 0, 1023)};
    vecs[6] = '{ax0: 3,    ay0: 9, ax1: 5,  ay1: 1,    exp: mk(1'b1, 8, 2, 5, 1023, 1, 9)};

    rst = 1'b1;
    req_valid = 1'b0;
    finish = 1'b0;
    x0_in = '0; y0_in = '0; x1_in = '0; y1_in = '0;
    #1;
    chk_ctl("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_cfg("reset", mk(1'b0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_line($sformatf("vec%0d", i), vecs[i].ax0, vecs[i].ay0, vecs[i].ax1, vecs[i].ay1,
               vecs[i].exp, 2, 1'b0, 1'b0);
    end

    run_line("fin_in_setup", 0, 0, 10, 4, vecs[0].exp, 3, 1'b1, 1'b0);
    run_line("five_draw", 2, 1, 3, 9, vecs[1].exp, 5, 1'b0, 1'b0);
    run_line("hold_valid", 8, 2, 0, 6, vecs[2].exp, 2, 1'b0, 1'b1);
    run_line("point_fin", 5, 5, 5, 5, vecs[3].exp, 1, 1'b1, 1'b1);

    // Reset during the third DRAW cycle abandons the line.
    @(negedge clk);
    x0_in = 10'd0; y0_in = 10'd0; x1_in = 10'd10; y1_in = 10'd4;
    req_valid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
    for (int d = 1; d <= 3; d++) begin
      @(negedge clk);
      chk($sformatf("rst_mid.draw%0d.en_FB_reg", d), {31'd0, en_FB_reg}, 32'd1);
    end
    #2 rst = 1'b1;
    #1;
    chk_ctl("rst_mid.async", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_cfg("rst_mid.async", mk(1'b0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("rst_mid.hold%0d.done", k), {31'd0, done}, 32'd0);
    end
    rst = 1'b0;
    run_line("after_rst", 2, 1, 3, 9, vecs[1].exp, 2, 1'b0, 1'b0);

    for (int r = 0; r < 40; r++) begin
      int a0, b0, a1, b1;
      a0 = int'($urandom_range(0, 1023));
      b0 = int'($urandom_range(0, 1023));
      a1 = int'($urandom_range(0, 1023));
      b1 = int'($urandom_range(0, 1023));
      if (r % 8 == 0) begin
        a1 = a0;
        b1 = b0;
      end
      run_line($sformatf("rnd%0d", r), a0, b0, a1, b1, model(a0, b0, a1, b1),
               int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_setup_controller.md
LINE_SETUP_CONTROLLER -- requirements
Module: line_setup_controller

Interface
REQ-001 SHALL have parameter WIDTH, default 10, the coordinate and delta width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port req_valid, input, 1, a line request is present.
REQ-005 SHALL have port req_ready, output, 1, high only in IDLE; a request is accepted on an edge where req_valid && req_ready.
REQ-006 SHALL have ports x0_in, y0_in, x1_in, y1_in, input, WIDTH each, unsigned line endpoints sampled at acceptance.
REQ-007 SHALL have port finish, input, 1, last-fragment indication from the fragment generator.
REQ-008 SHALL have port start, output, 1, one-cycle load pulse to the fragment generator.
REQ-009 SHALL have port en_FB_reg, output, 1, enables the frame-buffer address/colour register during drawing.
REQ-010 SHALL have port steep, output, 1, set when the line was transposed.
REQ-011 SHALL have ports deltax, deltay, y0, ystep, x0, x_min, x_max, output, WIDTH each, registered fragment-generator configuration.
REQ-012 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-013 SHALL have port done, output, 1, one-cycle pulse when a line completes.

Function
REQ-014 SHALL implement FSM states IDLE, SETUP_STEEP, SETUP_ORDER, SETUP_DELTA, START, DRAW, DONE.
REQ-015 IDLE: acceptance latches the four endpoints into working registers and moves to SETUP_STEEP; otherwise stays in IDLE.
REQ-016 SETUP_STEEP: steep = (|y1-y0| > |x1-x0|), using WIDTH+1-bit unsigned magnitudes; if steep, swap x with y for both endpoints; next SETUP_ORDER.
REQ-017 SETUP_ORDER: if working x0 > x1, exchange endpoint 0 and endpoint 1; next SETUP_DELTA.
REQ-018 SETUP_DELTA: deltax = x1-x0; deltay = |y1-y0|; ystep = 1 when y0 <= y1, else all-ones (two's-complement -1); x0 = x_min = working x0; x_max = working x1; y0 = working y0; next START.
REQ-019 START: start = 1 for exactly this cycle; next DRAW; the start pulse occurs on the 4th cycle after the acceptance edge.
REQ-020 DRAW: en_FB_reg = 1 in every DRAW cycle; stays until finish is sampled high, then goes to DONE.
REQ-021 finish SHALL be ignored in every state other than DRAW.
REQ-022 DONE: done = 1 for one cycle; next IDLE, where req_ready = 1.
REQ-023 Configuration outputs (steep, deltax, deltay, y0, ystep, x0, x_min, x_max) SHALL be stable from START until the next acceptance.
REQ-024 A degenerate line (both endpoints equal) SHALL still pass through START and DRAW, with deltax = deltay = 0, ystep = 1, and steep = 0.
REQ-025 req_valid while busy SHALL be ignored (not queued); the requester must hold it until req_ready.
REQ-026 start, en_FB_reg, and done SHALL be mutually exclusive in any cycle.

Reset
REQ-027 rst high SHALL immediately force IDLE, with req_ready = 1 and busy = start = en_FB_reg = done = 0.
REQ-028 rst high SHALL immediately clear steep, deltax, deltay, y0, ystep, x0, x_min, x_max, and the working registers to 0.
REQ-029 Reset asserted mid-setup or mid-DRAW SHALL abandon the line with no done pulse; the first acceptance after release starts fresh.

Verification
REQ-030 Shallow line (0,0)-(10,4) -> steep=0, x_min=x0=0, x_max=10, deltax=10, deltay=4, y0=0, ystep=1; start on the 4th cycle after acceptance.
REQ-031 Steep line (2,1)-(3,9) -> steep=1, x_min=1, x_max=9, deltax=8, deltay=1, y0=2, ystep=1.
REQ-032 Reversed negative slope (8,2)-(0,6) -> steep=0, x_min=0, x_max=8, deltax=8, deltay=4, y0=6, ystep=0x3FF.
REQ-033 Handshake and sequencing:
- finish held high during setup -> ignored;
- finish pulsed after 5 DRAW cycles -> exactly 5 en_FB_reg cycles, then one done pulse, then req_ready=1;
- req_valid held while busy -> no second acceptance until IDLE.
REQ-034 Point (5,5)-(5,5) -> deltax=0, deltay=0, steep=0, ystep=1; full START/DRAW/DONE sequence completes when finish is asserted.
REQ-035 Reset asserted during the 3rd DRAW cycle -> en_FB_reg and busy drop asynchronously, all configuration outputs read 0, no done pulse, req_ready=1.
